// File: rtl/ifmap_addr_gen_layer_3_pkg.sv
// Shared layer-3 constants and the signed row/col coordinate type used by
// the input-feature-map address generator and its padding check.
package ifmap_addr_gen_layer_3_pkg;

    localparam int FM_W    = 30;
    localparam int FM_H    = 30;
    localparam int K       = 3;
    localparam int PAD     = 1;
    localparam int FM_SIZE = FM_W * FM_H;

    localparam int COORD_W = 7;
    typedef logic signed [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pad_check_layer_3.sv
// Combinational tap-to-input coordinate mapping with zero-padding detection:
// row/col = output pixel + kernel tap - PAD, pad when either leaves the map.
module pad_check_layer_3
    import ifmap_addr_gen_layer_3_pkg::*;
#(
    parameter int FM_W  = ifmap_addr_gen_layer_3_pkg::FM_W,
    parameter int FM_H  = ifmap_addr_gen_layer_3_pkg::FM_H,
    parameter int PAD   = ifmap_addr_gen_layer_3_pkg::PAD,
    parameter int X_W   = 5,
    parameter int Y_W   = 5,
    parameter int TAP_W = 2
) (
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [TAP_W-1:0] kx,
    input  logic [TAP_W-1:0] ky,
    output coord_t           row,
    output coord_t           col,
    output logic             pad
);

    coord_t x_s;
    coord_t y_s;
    coord_t kx_s;
    coord_t ky_s;

    always_comb begin
        // zero-extend into the signed domain so x + kx - PAD can go to -PAD
        x_s  = coord_t'({{(COORD_W-X_W){1'b0}}, x});
        y_s  = coord_t'({{(COORD_W-Y_W){1'b0}}, y});
        kx_s = coord_t'({{(COORD_W-TAP_W){1'b0}}, kx});
        ky_s = coord_t'({{(COORD_W-TAP_W){1'b0}}, ky});

        row = y_s + ky_s - coord_t'(PAD);
        col = x_s + kx_s - coord_t'(PAD);

        pad = row[COORD_W-1] | (row >= coord_t'(FM_H))
            | col[COORD_W-1] | (col >= coord_t'(FM_W));
    end

endmodule

// File: rtl/ifmap_addr_gen_layer_3.sv
// Layer-3 input-feature-map read-address generator: two-stage pipeline from
// (x, y, kx, ky, ch) to SRAM address with padding flag, stall and frame tag.
module ifmap_addr_gen_layer_3
    import ifmap_addr_gen_layer_3_pkg::*;
#(
    parameter int FM_W   = ifmap_addr_gen_layer_3_pkg::FM_W,
    parameter int FM_H   = ifmap_addr_gen_layer_3_pkg::FM_H,
    parameter int K      = ifmap_addr_gen_layer_3_pkg::K,
    parameter int PAD    = ifmap_addr_gen_layer_3_pkg::PAD,
    parameter int CH_W   = 6,
    parameter int ADDR_W = 16,
    localparam int X_W   = $clog2(FM_W),
    localparam int Y_W   = $clog2(FM_H),
    localparam int TAP_W = $clog2(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              hold,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [TAP_W-1:0]  kx,
    input  logic [TAP_W-1:0]  ky,
    input  logic [CH_W-1:0]   ch,
    input  logic              frame_last,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pad_zero,
    output logic              out_valid,
    output logic              out_last
);

    localparam int CH_STRIDE = FM_W * FM_H;

    coord_t row_c;
    coord_t col_c;
    logic   pad_c;

    pad_check_layer_3 #(
        .FM_W  (FM_W),
        .FM_H  (FM_H),
        .PAD   (PAD),
        .X_W   (X_W),
        .Y_W   (Y_W),
        .TAP_W (TAP_W)
    ) u_pad_check (
        .x   (x),
        .y   (y),
        .kx  (kx),
        .ky  (ky),
        .row (row_c),
        .col (col_c),
        .pad (pad_c)
    );

    // Stage 1
    logic              s1_valid_q,   s1_valid_d;
    logic              s1_last_q,    s1_last_d;
    logic              s1_pad_q,     s1_pad_d;
    coord_t            s1_row_q,     s1_row_d;
    coord_t            s1_col_q,     s1_col_d;
    logic [ADDR_W-1:0] s1_ch_base_q, s1_ch_base_d;

    // Stage 2 (drives the outputs directly)
    logic              rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic              pad_zero_q,  pad_zero_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s1_pad_d     = s1_pad_q;
        s1_row_d     = s1_row_q;
        s1_col_d     = s1_col_q;
        s1_ch_base_d = s1_ch_base_q;

        if (!hold) begin
            s1_valid_d   = in_valid;
            s1_last_d    = in_valid & frame_last;
            s1_pad_d     = pad_c;
            s1_row_d     = row_c;
            s1_col_d     = col_c;
            s1_ch_base_d = ADDR_W'(ch) * ADDR_W'(CH_STRIDE);
        end
    end

    always_comb begin
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        pad_zero_d  = pad_zero_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (!hold) begin
            out_valid_d = s1_valid_q;
            out_last_d  = s1_valid_q & s1_last_q;
            pad_zero_d  = s1_valid_q & s1_pad_q;
            rd_en_d     = s1_valid_q & ~s1_pad_q;
            // row/col are non-negative whenever pad is clear, so zero-extension is safe
            rd_addr_d   = s1_pad_q ? '0
                        : s1_ch_base_q
                          + ADDR_W'(unsigned'(s1_row_q)) * ADDR_W'(FM_W)
                          + ADDR_W'(unsigned'(s1_col_q));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_pad_q     <= 1'b0;
            s1_row_q     <= '0;
            s1_col_q     <= '0;
            s1_ch_base_q <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            pad_zero_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_pad_q     <= s1_pad_d;
            s1_row_q     <= s1_row_d;
            s1_col_q     <= s1_col_d;
            s1_ch_base_q <= s1_ch_base_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            pad_zero_q   <= pad_zero_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign pad_zero  = pad_zero_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ifmap_addr_gen_layer_3.sv
// Directed bench for the layer-3 ifmap address generator with hand-computed
// addresses, padding edges, hold freeze and mid-stream reset.
module tb_ifmap_addr_gen_layer_3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        hold;
    logic [4:0]  x;
    logic [4:0]  y;
    logic [1:0]  kx;
    logic [1:0]  ky;
    logic [5:0]  ch;
    logic        frame_last;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        pad_zero;
    logic        out_valid;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic v;
        int   xx, yy, kxx, kyy, cc;
        logic last;
        logic ev, een, epz;
        int   eaddr;
        logic el;
    } vec_t;

    vec_t tbl[$];

    ifmap_addr_gen_layer_3 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .hold       (hold),
        .x          (x),
        .y          (y),
        .kx         (kx),
        .ky         (ky),
        .ch         (ch),
        .frame_last (frame_last),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .pad_zero   (pad_zero),
        .out_valid  (out_valid),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int xx, input int yy, input int kxx,
                         input int kyy, input int cc, input logic last);
        in_valid   = v;
        x          = 5'(xx);
        y          = 5'(yy);
        kx         = 2'(kxx);
        ky         = 2'(kyy);
        ch         = 6'(cc);
        frame_last = last;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic een, input logic epz,
                           input int eaddr, input logic el);
        chk({tag, "_valid"}, int'(out_valid), int'(ev));
        chk({tag, "_rd_en"}, int'(rd_en), int'(een));
        chk({tag, "_pad_zero"}, int'(pad_zero), int'(epz));
        chk({tag, "_rd_addr"}, int'(rd_addr), eaddr);
        chk({tag, "_last"}, int'(out_last), int'(el));
    endtask

    initial begin
        rst  = 1'b0;
        hold = 1'b0;
        drive(1'b1, 5, 2, 1, 1, 0, 1'b1);
        tick();
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        rst = 1'b1;
        idle();
        tick();

        // top-left corner tap: row=-1, col=-1; output exactly two edges later
        drive(1'b1, 0, 0, 0, 0, 0, 1'b0);
        tick();
        chk("lat1_valid", int'(out_valid), 0);
        idle();
        tick();
        chk_out("corner00", 1'b1, 1'b0, 1'b1, 0, 1'b0);

        // back-to-back stream
        tbl.push_back('{1'b1,  5,  2, 1, 1,  0, 1'b0, 1'b1, 1'b1, 1'b0,    65, 1'b0});
        tbl.push_back('{1'b1, 29, 29, 2, 1,  0, 1'b0, 1'b1, 1'b0, 1'b1,     0, 1'b0});
        tbl.push_back('{1'b1, 29, 29, 1, 1,  0, 1'b0, 1'b1, 1'b1, 1'b0,   899, 1'b0});
        tbl.push_back('{1'b0,  7,  7, 1, 1,  1, 1'b1, 1'b0, 1'b0, 1'b0,     0, 1'b0});
        tbl.push_back('{1'b1,  3, 29, 1, 2,  0, 1'b0, 1'b1, 1'b0, 1'b1,     0, 1'b0});
        tbl.push_back('{1'b1, 29,  0, 2, 0,  0, 1'b0, 1'b1, 1'b0, 1'b1,     0, 1'b0});
        tbl.push_back('{1'b1,  0,  0, 1, 1,  3, 1'b1, 1'b1, 1'b1, 1'b0,  2700, 1'b1});
        tbl.push_back('{1'b1, 29, 29, 1, 1, 63, 1'b0, 1'b1, 1'b1, 1'b0, 57599, 1'b0});
        tbl.push_back('{1'b1,  0,  4, 0, 1,  1, 1'b0, 1'b1, 1'b0, 1'b1,     0, 1'b0});
        tbl.push_back('{1'b1,  4,  0, 1, 0,  2, 1'b0, 1'b1, 1'b0, 1'b1,     0, 1'b0});
        tbl.push_back('{1'b1,  1,  0, 0, 1,  0, 1'b0, 1'b1, 1'b1, 1'b0,     0, 1'b0});

        for (int i = 0; i <= tbl.size(); i++) begin
            if (i < tbl.size())
                drive(tbl[i].v, tbl[i].xx, tbl[i].yy, tbl[i].kxx, tbl[i].kyy, tbl[i].cc, tbl[i].last);
            else
                idle();
            tick();
            if (i >= 1) begin
                chk($sformatf("s%0d_valid", i-1), int'(out_valid), int'(tbl[i-1].ev));
                chk($sformatf("s%0d_rd_en", i-1), int'(rd_en), int'(tbl[i-1].een));
                chk($sformatf("s%0d_pad_zero", i-1), int'(pad_zero), int'(tbl[i-1].epz));
                chk($sformatf("s%0d_last", i-1), int'(out_last), int'(tbl[i-1].el));
                if (tbl[i-1].ev)
                    chk($sformatf("s%0d_rd_addr", i-1), int'(rd_addr), tbl[i-1].eaddr);
            end
        end
        idle();
        tick();

        // hold for 3 cycles after the 2nd accept
        drive(1'b1, 1, 1, 1, 1, 1, 1'b0);      // A -> 931
        tick();
        drive(1'b1, 10, 4, 0, 2, 2, 1'b0);     // B -> 1959
        tick();
        chk_out("holdA", 1'b1, 1'b1, 1'b0, 931, 1'b0);
        hold = 1'b1;
        drive(1'b1, 0, 0, 0, 0, 7, 1'b1);      // ignored while held
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("frozen%0d", i), 1'b1, 1'b1, 1'b0, 931, 1'b0);
        end
        hold = 1'b0;
        drive(1'b1, 20, 15, 2, 0, 0, 1'b0);    // C -> 441
        tick();
        chk_out("holdB", 1'b1, 1'b1, 1'b0, 1959, 1'b0);
        drive(1'b1, 7, 8, 1, 1, 5, 1'b0);      // D -> 4747
        tick();
        chk_out("holdC", 1'b1, 1'b1, 1'b0, 441, 1'b0);
        idle();
        tick();
        chk_out("holdD", 1'b1, 1'b1, 1'b0, 4747, 1'b0);
        tick();
        chk("hold_nodup_valid", int'(out_valid), 0);

        // asynchronous reset mid-stream
        drive(1'b1, 1, 1, 1, 1, 1, 1'b1);
        tick();
        drive(1'b1, 10, 4, 0, 2, 2, 1'b0);
        tick();
        chk_out("prerst", 1'b1, 1'b1, 1'b0, 931, 1'b1);
        idle();
        #1 rst = 1'b0;
        #1;
        chk_out("inrst", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("postrst0_valid", int'(out_valid), 0);
        tick();
        chk("postrst1_valid", int'(out_valid), 0);
        drive(1'b1, 5, 2, 1, 1, 0, 1'b0);
        tick();
        chk("postrst2_valid", int'(out_valid), 0);
        idle();
        tick();
        chk_out("postrst_new", 1'b1, 1'b1, 1'b0, 65, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
